fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the RISC-V pipeline front end. Owns the program counter, runs the request/ready handshake with instruction memory, and drives the load-enable and flush of the IF/ID instruction register (`instr_reg`). It supplies that register's `instruction_next`, `pc_next` and `pc_plus_four_next` inputs. It absorbs memory wait states, decode hazard stalls and branch/jump redirects.

---
 rtl/fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_fetch_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request/ready handshake
// and drives the IF/ID register load/flush, absorbing wait states, stalls and redirects.
module fetch_ctrl #(
    parameter int unsigned   n        = 32,
    parameter logic [n-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [n-1:0] imem_rdata,
    input  logic         hazard_stall,
    input  logic         redirect,
    input  logic [n-1:0] redirect_pc,
    output logic         ir_en,
    output logic         ir_flush,
    output logic [n-1:0] instruction_next,
    output logic [n-1:0] pc_next,
    output logic [n-1:0] pc_plus_four_next
);

    localparam logic [n-1:0] NOP  = n'(32'h0000_0013);
    localparam logic [n-1:0] FOUR = n'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t       state;
    logic [n-1:0] pc;
    logic [n-1:0] pc_inc;
    logic [n-1:0] buf_instr;
    logic         buf_valid;
    logic         kill;
    logic [n-1:0] pend_pc;

    assign pc_inc = pc + FOUR;

    // State, PC, one-entry response buffer and kill tracking for an abandoned request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            buf_instr <= '0;
            buf_valid <= 1'b0;
            kill      <= 1'b0;
            pend_pc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                    state <= FETCH;
                end
                FETCH: begin
                    if (redirect) begin
                        if (imem_ready) begin
                            pc   <= redirect_pc;
                            kill <= 1'b0;
                        end else begin
                            // Request stays outstanding; its response will be dropped.
                            kill    <= 1'b1;
                            pend_pc <= redirect_pc;
                        end
                    end else if (imem_ready) begin
                        if (kill) begin
                            pc   <= pend_pc;
                            kill <= 1'b0;
                        end else if (hazard_stall) begin
                            buf_instr <= imem_rdata;
                            buf_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        buf_valid <= 1'b0;
                        pc        <= redirect_pc;
                        state     <= FETCH;
                    end else if (!hazard_stall) begin
                        buf_valid <= 1'b0;
                        pc        <= pc_inc;
                        state     <= FETCH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are combinational; the IF/ID register downstream does the registering.
    always_comb begin
        imem_req          = 1'b0;
        imem_addr         = '0;
        ir_en             = 1'b0;
        ir_flush          = 1'b0;
        instruction_next  = '0;
        pc_next           = '0;
        pc_plus_four_next = '0;
        if (!reset) begin
            imem_addr         = pc;
            pc_next           = pc;
            pc_plus_four_next = pc_inc;
            instruction_next  = NOP;
            ir_flush          = redirect;
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (!redirect && imem_ready && !kill && !hazard_stall) begin
                        ir_en            = 1'b1;
                        instruction_next = imem_rdata;
                    end
                end
                HOLD: begin
                    if (!redirect && !hazard_stall && buf_valid) begin
                        ir_en            = 1'b1;
                        instruction_next = buf_instr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based reference model.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        hazard_stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        ir_en;
    logic        ir_flush;
    logic [31:0] instruction_next;
    logic [31:0] pc_next;
    logic [31:0] pc_plus_four_next;

    logic        d2_req;
    logic [31:0] d2_addr;
    logic        d2_ir_en;
    logic        d2_ir_flush;
    logic [31:0] d2_instr;
    logic [31:0] d2_pc_next;
    logic [31:0] d2_p4;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_ctrl #(.n(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .hazard_stall(hazard_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ir_en(ir_en), .ir_flush(ir_flush), .instruction_next(instruction_next),
        .pc_next(pc_next), .pc_plus_four_next(pc_plus_four_next)
    );

    fetch_ctrl #(.n(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(d2_req), .imem_addr(d2_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .hazard_stall(hazard_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ir_en(d2_ir_en), .ir_flush(d2_ir_flush), .instruction_next(d2_instr),
        .pc_next(d2_pc_next), .pc_plus_four_next(d2_p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a fetcher is idle, holding a word (m_held non-empty) or fetching;
    // m_kill holds the restart address of a request whose response must be dropped.
    logic        m_idle;
    logic [31:0] m_pc;
    logic [31:0] m_held[$];
    logic [31:0] m_kill[$];

    logic        e_req, e_en, e_flush;
    logic [31:0] e_addr, e_instr, e_pc_next, e_p4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_outputs();
        e_req = 0; e_addr = 0; e_en = 0; e_flush = 0; e_instr = 0; e_pc_next = 0; e_p4 = 0;
        if (!reset) begin
            e_req     = !m_idle && (m_held.size() == 0);
            e_addr    = m_pc;
            e_pc_next = m_pc;
            e_p4      = m_pc + 32'd4;
            e_flush   = redirect;
            e_instr   = NOP;
            if (!redirect && !m_idle && !hazard_stall) begin
                if (m_held.size() > 0) begin
                    e_en = 1; e_instr = m_held[0];
                end else if (imem_ready && m_kill.size() == 0) begin
                    e_en = 1; e_instr = imem_rdata;
                end
            end
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_idle = 1; m_pc = 32'h0; m_held.delete(); m_kill.delete();
        end else if (m_idle) begin
            if (redirect) m_pc = redirect_pc;
            m_idle = 0;
        end else if (m_held.size() > 0) begin
            if (redirect) begin
                m_held.delete(); m_pc = redirect_pc;
            end else if (!hazard_stall) begin
                m_held.delete(); m_pc = m_pc + 32'd4;
            end
        end else if (redirect) begin
            m_kill.delete();
            if (imem_ready) m_pc = redirect_pc;
            else m_kill.push_back(redirect_pc);
        end else if (imem_ready) begin
            if (m_kill.size() > 0) m_pc = m_kill.pop_front();
            else if (hazard_stall) m_held.push_back(imem_rdata);
            else m_pc = m_pc + 32'd4;
        end
    endtask

    // Sample at the falling edge and compare every output against the model.
    task automatic settle();
        @(negedge clk);
        model_outputs();
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("imem_addr", imem_addr, e_addr);
        chk("ir_en", 32'(ir_en), 32'(e_en));
        chk("ir_flush", 32'(ir_flush), 32'(e_flush));
        chk("instruction_next", instruction_next, e_instr);
        chk("pc_next", pc_next, e_pc_next);
        chk("pc_plus_four_next", pc_plus_four_next, e_p4);
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rst, input logic rdy, input logic [31:0] rd,
                          input logic stl, input logic rdr, input logic [31:0] rpc);
        reset = rst; imem_ready = rdy; imem_rdata = rd;
        hazard_stall = stl; redirect = rdr; redirect_pc = rpc;
    endtask

    initial begin
        m_idle = 1; m_pc = 0;
        set_in(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        settle();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_instr", instruction_next, 32'd0);
        advance();

        // Zero-wait stream
        set_in(0, 1, m_pc + 32'd1000, 0, 0, 0);
        settle();
        chk("zw_idle_req", 32'(imem_req), 32'd0);
        chk("zw_idle_en", 32'(ir_en), 32'd0);
        advance();
        for (int i = 0; i < 3; i++) begin
            imem_rdata = m_pc + 32'd1000;
            settle();
            chk("zw_en", 32'(ir_en), 32'd1);
            chk("zw_pc", pc_next, 32'(4 * i));
            chk("zw_instr", instruction_next, 32'(1000 + 4 * i));
            if (i == 0) begin
                chk("wrap_en", 32'(d2_ir_en), 32'd1);
                chk("wrap_pc", d2_pc_next, 32'hFFFF_FFFC);
                chk("wrap_p4", d2_p4, 32'h0);
            end
            if (i == 1) chk("wrap_addr", d2_addr, 32'h0);
            advance();
        end

        // Wait states
        set_in(1, 0, 0, 0, 0, 0); settle(); advance();
        reset = 0; settle(); advance();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ws_addr", imem_addr, 32'h0);
            chk("ws_req", 32'(imem_req), 32'd1);
            advance();
        end
        set_in(0, 1, 32'd55, 0, 0, 0);
        settle();
        chk("ws_en", 32'(ir_en), 32'd1);
        chk("ws_instr", instruction_next, 32'd55);
        chk("ws_p4", pc_plus_four_next, 32'd4);
        advance();

        // Stall on response
        set_in(0, 1, 32'd250, 1, 0, 0);
        settle();
        chk("st_en", 32'(ir_en), 32'd0);
        advance();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 1, 0, 0);
            settle();
            chk("st_hold_req", 32'(imem_req), 32'd0);
            advance();
        end
        hazard_stall = 0;
        settle();
        chk("st_rel_en", 32'(ir_en), 32'd1);
        chk("st_rel_instr", instruction_next, 32'd250);
        chk("st_rel_pc", pc_next, 32'd4);
        advance();
        settle();
        chk("st_resume_addr", imem_addr, 32'd8);
        advance();

        // Redirect while outstanding
        set_in(0, 0, 0, 0, 1, 32'h100);
        settle();
        chk("ro_flush", 32'(ir_flush), 32'd1);
        advance();
        set_in(0, 1, 32'd77, 0, 0, 0);
        settle();
        chk("ro_drop_en", 32'(ir_en), 32'd0);
        chk("ro_drop_flush", 32'(ir_flush), 32'd0);
        advance();
        set_in(0, 0, 0, 0, 0, 0);
        settle();
        chk("ro_addr", imem_addr, 32'h100);
        advance();

        // Simultaneous ready/redirect/stall, then redirect in HOLD
        set_in(0, 1, 32'hAA, 1, 1, 32'h200);
        settle();
        chk("sim_flush", 32'(ir_flush), 32'd1);
        chk("sim_en", 32'(ir_en), 32'd0);
        advance();
        set_in(0, 0, 0, 0, 0, 0);
        settle();
        chk("sim_addr", imem_addr, 32'h200);
        chk("sim_req", 32'(imem_req), 32'd1);
        advance();
        set_in(0, 1, 32'd99, 1, 0, 0); settle(); advance();
        set_in(0, 0, 0, 0, 1, 32'h300);
        settle();
        chk("hr_flush", 32'(ir_flush), 32'd1);
        chk("hr_req", 32'(imem_req), 32'd0);
        advance();
        set_in(0, 1, 32'h123, 0, 0, 0);
        settle();
        chk("hr_instr", instruction_next, 32'h123);
        chk("hr_pc", pc_next, 32'h300);
        advance();

        // Reset mid-wait
        set_in(0, 0, 0, 0, 0, 0); settle(); advance();
        reset = 1;
        settle();
        chk("rm_addr", imem_addr, 32'd0);
        chk("rm_p4", pc_plus_four_next, 32'd0);
        advance();
        reset = 0; settle(); advance();
        settle();
        chk("rm_restart_addr", imem_addr, 32'h0);
        chk("rm_restart_req", 32'(imem_req), 32'd1);
        advance();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            set_in(($urandom_range(99) == 0), 1'($urandom_range(1)), $urandom,
                   ($urandom_range(2) == 0), ($urandom_range(7) == 0), rpc);
            settle();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
